mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access stage of the five-stage MIPS pipeline plus the MEM/WB pipeline register. It issues loads and stores to a data memory with a variable-latency req/ack handshake, stalls the pipeline while an access is outstanding, and applies byte/halfword extension to load data. It registers the result bundle that drives the write-back result mux (ALUOut/ReadData/PC8 select).

## Interface
- DATA_W, default 32: datapath width. Only 32 is supported.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Valid_M  in  1  M-stage holds a real instruction (0 = bubble).
- ALUOut_M  in  32  ALU result; this is the memory address for loads and stores.
- WriteData_M  in  32  store data (rt).
- PC8_M  in  32  PC+8 of the instruction.
- WriteReg_M  in  5  destination register.
- RegWrite_M  in  1  register write enable.
- MUX_WD3_Sel_M  in  2  write-back select: 0 = ALUOut, 1 = ReadData, 2 = PC8.
- MemRead_M, MemWrite_M  in  1 each  load or store; mutually exclusive.
- LoadType_M  in  3  0 = lw, 1 = lb, 2 = lbu, 3 = lh, 4 = lhu.
- StoreType_M  in  2  0 = sw, 1 = sb, 2 = sh.
- dm_req  out  1  memory request.
- dm_we  out  1  1 = write.
- dm_addr  out  32  word-aligned address ({ALUOut_M[31:2], 2'b00}).
- dm_wdata  out  32  store data, replicated to lanes.
- dm_be  out  4  byte enables.
- dm_ack  in  1  request completes this cycle. For reads, dm_rdata is valid with it.
- dm_rdata  in  32  read word.
- Stall_M  out  1  freeze PC/F/D/E/M registers this cycle.
- ReadData_W, ALUOut_W, PC8_W  out  32 each  registered results.
- WriteReg_W  out  5  registered destination register.
- RegWrite_W  out  1  registered register write enable.
- MUX_WD3_W_Sel  out  2  registered write-back select.
- AdExc_W  out  1  registered misaligned-access flag.

## Operation
- Mem op = Valid_M & (MemRead_M | MemWrite_M) & aligned.
- Alignment rules:
  - lw/sw require ALUOut_M[1:0] == 0.
  - lh/lhu/sh require ALUOut_M[0] == 0.
  - Byte accesses are always aligned.
- FSM states: IDLE, WAIT.
  - IDLE: dm_req = mem op (combinational).
    - dm_ack = 1 in the same cycle: access completes, stay in IDLE.
    - dm_ack = 0: go to WAIT.
  - WAIT: dm_req = 1, outputs held.
    - dm_ack = 1: go to IDLE.
- Stall_M = mem op & ~dm_ack, in both states.
- Upstream holds all *_M inputs stable while Stall_M = 1.
- dm_we = MemWrite_M.
- Byte enables:
  - sw: 1111.
  - sh: 0011 << ALUOut_M[1:0].
  - sb: 0001 << ALUOut_M[1:0].
- Store data lanes:
  - sw: dm_wdata = WriteData_M.
  - sh: dm_wdata = {2{WriteData_M[15:0]}}.
  - sb: dm_wdata = {4{WriteData_M[7:0]}}.
- Load extension: select the byte/halfword at offset ALUOut_M[1:0] (halfword selected by bit 1).
  - lb, lh: sign-extend.
  - lbu, lhu: zero-extend.
  - lw: pass the word through.
- Misaligned, Valid_M = 1: no dm_req and no stall. The W register gets AdExc_W = 1 and RegWrite_W = 0; the other fields pass through.
- W register update, every cycle:
  - Stall_M = 1: capture a bubble (RegWrite_W = 0, AdExc_W = 0; other fields don't-care, hold previous).
  - Otherwise: capture the M bundle. ReadData_W gets the extended load data when MemRead_M, else 0.
  - Valid_M = 0: RegWrite_W = 0.

## Timing
- Reset: state = IDLE; all W outputs = 0. dm_req = 0 while reset_n = 0.
- Zero-wait memory: a load's data appears on ReadData_W 1 cycle after the M cycle. No stall.
- N-wait memory: Stall_M is high for N cycles. Data is registered on the edge ending the ack cycle.
- Non-memory instructions pass through in 1 cycle.
- reset_n asserted during WAIT: return to IDLE immediately and drop dm_req. A late dm_ack is ignored.
- dm_ack while dm_req = 0: ignored.

## Structure
- Shared package (mips_defs): LoadType/StoreType encodings, MUX_WD3 select codes, FSM state encoding.
- One sub-module, load_ext: a combinational byte/halfword select and extend (rdata, offset, LoadType → 32-bit).

## Test plan
- lw 0x100, memory returns 0xDEADBEEF with ack in the same cycle → ReadData_W = 0xDEADBEEF one cycle later, Stall_M never high.
- lb at 0x103, word 0x80FF7F01, ack after 3 cycles → Stall_M high for exactly 3 cycles, ReadData_W = 0xFFFFFF80. lbu at the same address → 0x00000080.
- sh 0x102, WriteData 0x1234ABCD → dm_be = 1100, dm_wdata = 0xABCDABCD, dm_we = 1, RegWrite_W = 0.
- lw at 0x101 → no dm_req, AdExc_W = 1, RegWrite_W = 0, no stall.
- jal-style instruction (Sel = 2, PC8_M = 0x3008) → PC8_W = 0x3008 and MUX_WD3_W_Sel = 2 the next cycle. The write-back result equals 0x3008.
- reset_n pulsed low during WAIT → all W outputs 0 and dm_req = 0 immediately. After release, FSM is in IDLE and a new lw completes normally.

Source files
------------

// File: rtl/mips_defs.sv
// -----------------------------------------------------------------------------
// mips_defs
// Shared encodings for the MIPS memory-access / write-back stage:
//   load_type_e  : LoadType_M encodings (lw, lb, lbu, lh, lhu)
//   store_type_e : StoreType_M encodings (sw, sb, sh)
//   wd3_sel_e    : write-back result mux select codes
//   mem_state_e  : memory handshake FSM state encoding
//   access_aligned() : alignment rule for a load/store at a byte offset
// -----------------------------------------------------------------------------
package mips_defs;

  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LB  = 3'd1,
    LT_LBU = 3'd2,
    LT_LH  = 3'd3,
    LT_LHU = 3'd4
  } load_type_e;

  typedef enum logic [1:0] {
    ST_SW = 2'd0,
    ST_SB = 2'd1,
    ST_SH = 2'd2
  } store_type_e;

  typedef enum logic [1:0] {
    WD3_ALU = 2'd0,
    WD3_MEM = 2'd1,
    WD3_PC8 = 2'd2
  } wd3_sel_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_e;

  // Words need offset 0, halfwords an even offset; bytes are always aligned.
  // Undefined type codes are treated as byte-sized and never trap.
  function automatic logic access_aligned(
    input logic       mem_read,
    input logic       mem_write,
    input logic [2:0] load_type,
    input logic [1:0] store_type,
    input logic [1:0] offset
  );
    logic ok;
    ok = 1'b1;
    if (mem_read) begin
      case (load_type)
        LT_LW:          ok = (offset == 2'b00);
        LT_LH, LT_LHU:  ok = ~offset[0];
        default:        ok = 1'b1;
      endcase
    end else if (mem_write) begin
      case (store_type)
        ST_SW:   ok = (offset == 2'b00);
        ST_SH:   ok = ~offset[0];
        default: ok = 1'b1;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// -----------------------------------------------------------------------------
// load_ext
// Combinational load-data formatter: picks the byte or halfword addressed by
// the low address bits out of the returned memory word and sign- or
// zero-extends it to 32 bits. lw passes the word through.
//   rdata_i     : 32-bit word returned by data memory
//   offset_i    : byte offset within the word (address[1:0])
//   load_type_i : load_type_e encoding
//   data_o      : extended 32-bit load result
// -----------------------------------------------------------------------------
module load_ext
  import mips_defs::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  load_type_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
    endcase
    // Halfword lane is chosen by bit 1 only; bit 0 is zero for aligned lh/lhu.
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    data_o = rdata_i;
    case (load_type_i)
      LT_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  data_o = {24'h0, byte_sel};
      LT_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  data_o = {16'h0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// MIPS memory-access stage plus the MEM/WB pipeline register.
//  - Issues loads/stores on a req/ack data-memory port with variable latency
//    and stalls the upstream pipeline while an access is outstanding.
//  - Builds byte enables / replicated store lanes for sb/sh/sw.
//  - Extends lb/lbu/lh/lhu load data (load_ext).
//  - Flags misaligned accesses (AdExc_W) instead of issuing them.
// Ports:
//  clk, reset_n                  : clock, async active-low reset
//  *_M inputs                    : M-stage instruction bundle
//  dm_req/we/addr/wdata/be       : data memory request side
//  dm_ack/dm_rdata               : data memory completion / read data
//  Stall_M                       : freeze PC/F/D/E/M this cycle
//  *_W outputs, AdExc_W          : registered write-back bundle
// -----------------------------------------------------------------------------
module mem_wb_stage
  import mips_defs::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              Valid_M,
  input  logic [DATA_W-1:0] ALUOut_M,
  input  logic [DATA_W-1:0] WriteData_M,
  input  logic [DATA_W-1:0] PC8_M,
  input  logic [4:0]        WriteReg_M,
  input  logic              RegWrite_M,
  input  logic [1:0]        MUX_WD3_Sel_M,
  input  logic              MemRead_M,
  input  logic              MemWrite_M,
  input  logic [2:0]        LoadType_M,
  input  logic [1:0]        StoreType_M,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic [3:0]        dm_be,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              Stall_M,
  output logic [DATA_W-1:0] ReadData_W,
  output logic [DATA_W-1:0] ALUOut_W,
  output logic [DATA_W-1:0] PC8_W,
  output logic [4:0]        WriteReg_W,
  output logic              RegWrite_W,
  output logic [1:0]        MUX_WD3_W_Sel,
  output logic              AdExc_W
);

  mem_state_e state_q, state_d;

  logic              is_mem;
  logic              aligned;
  logic              mem_op;
  logic              misaligned;
  logic [DATA_W-1:0] load_data;

  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic [DATA_W-1:0] alu_out_q,   alu_out_d;
  logic [DATA_W-1:0] pc8_q,       pc8_d;
  logic [4:0]        write_reg_q, write_reg_d;
  logic              reg_write_q, reg_write_d;
  logic [1:0]        wd3_sel_q,   wd3_sel_d;
  logic              adexc_q,     adexc_d;

  // ---------------------------------------------------------------------------
  // Access classification
  // ---------------------------------------------------------------------------
  assign is_mem     = Valid_M & (MemRead_M | MemWrite_M);
  assign aligned    = access_aligned(MemRead_M, MemWrite_M, LoadType_M,
                                     StoreType_M, ALUOut_M[1:0]);
  assign mem_op     = is_mem & aligned;
  assign misaligned = is_mem & ~aligned;

  // ---------------------------------------------------------------------------
  // Handshake FSM: IDLE issues combinationally; WAIT keeps the request up
  // until the ack arrives. Upstream holds the M bundle while stalled, so the
  // request fields stay stable across WAIT.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples pre-edge values regardless of block order.
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mem_op && !dm_ack) state_d = S_WAIT;
      S_WAIT:  if (dm_ack)            state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Requests and stalls are gated by reset so an in-flight access drops the
  // moment reset asserts, not at the next edge.
  assign dm_req  = reset_n & (mem_op | (state_q == S_WAIT));
  assign Stall_M = reset_n & mem_op & ~dm_ack;

  // ---------------------------------------------------------------------------
  // Request payload
  // ---------------------------------------------------------------------------
  assign dm_we   = MemWrite_M;
  assign dm_addr = {ALUOut_M[DATA_W-1:2], 2'b00};

  always_comb begin
    dm_be    = 4'b1111;
    dm_wdata = WriteData_M;
    case (StoreType_M)
      ST_SB: begin
        dm_be    = 4'b0001 << ALUOut_M[1:0];
        dm_wdata = {4{WriteData_M[7:0]}};
      end
      ST_SH: begin
        dm_be    = 4'b0011 << ALUOut_M[1:0];
        dm_wdata = {2{WriteData_M[15:0]}};
      end
      default: begin
        dm_be    = 4'b1111;
        dm_wdata = WriteData_M;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load extension
  // ---------------------------------------------------------------------------
  load_ext u_load_ext (
    .rdata_i     (dm_rdata),
    .offset_i    (ALUOut_M[1:0]),
    .load_type_i (LoadType_M),
    .data_o      (load_data)
  );

  // ---------------------------------------------------------------------------
  // MEM/WB register: a stalled cycle inserts a bubble (no write, no trap) and
  // leaves the data fields as they were.
  // ---------------------------------------------------------------------------
  always_comb begin
    read_data_d = read_data_q;
    alu_out_d   = alu_out_q;
    pc8_d       = pc8_q;
    write_reg_d = write_reg_q;
    wd3_sel_d   = wd3_sel_q;
    reg_write_d = 1'b0;
    adexc_d     = 1'b0;
    if (!Stall_M) begin
      read_data_d = MemRead_M ? load_data : '0;
      alu_out_d   = ALUOut_M;
      pc8_d       = PC8_M;
      write_reg_d = WriteReg_M;
      wd3_sel_d   = MUX_WD3_Sel_M;
      reg_write_d = Valid_M & RegWrite_M & ~misaligned;
      adexc_d     = misaligned;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data_q <= '0;
      alu_out_q   <= '0;
      pc8_q       <= '0;
      write_reg_q <= '0;
      reg_write_q <= 1'b0;
      wd3_sel_q   <= '0;
      adexc_q     <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      alu_out_q   <= alu_out_d;
      pc8_q       <= pc8_d;
      write_reg_q <= write_reg_d;
      reg_write_q <= reg_write_d;
      wd3_sel_q   <= wd3_sel_d;
      adexc_q     <= adexc_d;
    end
  end

  assign ReadData_W    = read_data_q;
  assign ALUOut_W      = alu_out_q;
  assign PC8_W         = pc8_q;
  assign WriteReg_W    = write_reg_q;
  assign RegWrite_W    = reg_write_q;
  assign MUX_WD3_W_Sel = wd3_sel_q;
  assign AdExc_W       = adexc_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
// Self-checking bench for mem_wb_stage. Each M-stage cycle pushes the
// expected MEM/WB contents onto a queue; a monitor pops one entry after every
// rising edge and compares it with the W outputs. The bench also plays the
// data memory, acking after a per-instruction latency.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

  logic        clk;
  logic        reset_n;
  logic        Valid_M;
  logic [31:0] ALUOut_M;
  logic [31:0] WriteData_M;
  logic [31:0] PC8_M;
  logic [4:0]  WriteReg_M;
  logic        RegWrite_M;
  logic [1:0]  MUX_WD3_Sel_M;
  logic        MemRead_M;
  logic        MemWrite_M;
  logic [2:0]  LoadType_M;
  logic [1:0]  StoreType_M;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        Stall_M;
  logic [31:0] ReadData_W;
  logic [31:0] ALUOut_W;
  logic [31:0] PC8_W;
  logic [4:0]  WriteReg_W;
  logic        RegWrite_W;
  logic [1:0]  MUX_WD3_W_Sel;
  logic        AdExc_W;

  mem_wb_stage #(.DATA_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .Valid_M       (Valid_M),
    .ALUOut_M      (ALUOut_M),
    .WriteData_M   (WriteData_M),
    .PC8_M         (PC8_M),
    .WriteReg_M    (WriteReg_M),
    .RegWrite_M    (RegWrite_M),
    .MUX_WD3_Sel_M (MUX_WD3_Sel_M),
    .MemRead_M     (MemRead_M),
    .MemWrite_M    (MemWrite_M),
    .LoadType_M    (LoadType_M),
    .StoreType_M   (StoreType_M),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_be         (dm_be),
    .dm_ack        (dm_ack),
    .dm_rdata      (dm_rdata),
    .Stall_M       (Stall_M),
    .ReadData_W    (ReadData_W),
    .ALUOut_W      (ALUOut_W),
    .PC8_W         (PC8_W),
    .WriteReg_W    (WriteReg_W),
    .RegWrite_W    (RegWrite_W),
    .MUX_WD3_W_Sel (MUX_WD3_W_Sel),
    .AdExc_W       (AdExc_W)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        valid;
    logic        mr;
    logic        mw;
    logic        rw;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc8;
    logic [4:0]  wreg;
    logic [1:0]  sel;
    logic [2:0]  lt;
    logic [1:0]  st;
  } instr_t;

  typedef struct {
    string       tag;
    logic        full;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [31:0] pc8;
    logic [4:0]  wreg;
    logic        rw;
    logic [1:0]  sel;
    logic        adexc;
  } wexp_t;

  int    n_checks = 0;
  int    n_errors = 0;
  wexp_t exp_q[$];
  wexp_t mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic instr_t nop();
    instr_t i;
    i.valid = 0; i.mr = 0; i.mw = 0; i.rw = 0;
    i.alu = '0; i.wd = '0; i.pc8 = '0; i.wreg = '0;
    i.sel = '0; i.lt = '0; i.st = '0;
    return i;
  endfunction

  function automatic instr_t mk_load(input logic [2:0] lt, input logic [31:0] a, input logic [4:0] r);
    instr_t i = nop();
    i.valid = 1; i.mr = 1; i.rw = 1; i.sel = 2'd1; i.lt = lt;
    i.alu = a; i.wreg = r; i.pc8 = 32'h0000_4000 + a; i.wd = 32'hCAFE_F00D;
    return i;
  endfunction

  function automatic instr_t mk_store(input logic [1:0] st, input logic [31:0] a, input logic [31:0] d);
    instr_t i = nop();
    i.valid = 1; i.mw = 1; i.st = st; i.alu = a; i.wd = d;
    i.pc8 = 32'h0000_5008; i.wreg = 5'd3;
    return i;
  endfunction

  function automatic logic m_aligned(input instr_t i);
    if (i.mr) begin
      if (i.lt == 3'd0) return i.alu[1:0] == 2'b00;
      if (i.lt == 3'd3 || i.lt == 3'd4) return i.alu[0] == 1'b0;
      return 1'b1;
    end
    if (i.mw) begin
      if (i.st == 2'd0) return i.alu[1:0] == 2'b00;
      if (i.st == 2'd2) return i.alu[0] == 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_ext(input instr_t i, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * i.alu[1:0])) & 32'h0000_00FF;
    h = (w >> (16 * i.alu[1])) & 32'h0000_FFFF;
    case (i.lt)
      3'd1:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input instr_t i);
    case (i.st)
      2'd1:    return 4'b0001 << i.alu[1:0];
      2'd2:    return i.alu[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input instr_t i);
    case (i.st)
      2'd1:    return {i.wd[7:0], i.wd[7:0], i.wd[7:0], i.wd[7:0]};
      2'd2:    return {i.wd[15:0], i.wd[15:0]};
      default: return i.wd;
    endcase
  endfunction

  function automatic logic [31:0] wb_mux(input logic [1:0] sel, input logic [31:0] alu,
                                         input logic [31:0] rd, input logic [31:0] pc8);
    case (sel)
      2'd1:    return rd;
      2'd2:    return pc8;
      default: return alu;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: one expectation per rising edge while entries are pending
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.tag, ":RegWrite_W"}, {31'd0, RegWrite_W}, {31'd0, mon_e.rw});
      check({mon_e.tag, ":AdExc_W"},    {31'd0, AdExc_W},    {31'd0, mon_e.adexc});
      if (mon_e.full) begin
        check({mon_e.tag, ":ReadData_W"}, ReadData_W, mon_e.rd);
        check({mon_e.tag, ":ALUOut_W"},   ALUOut_W,   mon_e.alu);
        check({mon_e.tag, ":PC8_W"},      PC8_W,      mon_e.pc8);
        check({mon_e.tag, ":WriteReg_W"}, {27'd0, WriteReg_W},    {27'd0, mon_e.wreg});
        check({mon_e.tag, ":Sel_W"},      {30'd0, MUX_WD3_W_Sel}, {30'd0, mon_e.sel});
        check({mon_e.tag, ":wb_result"},
              wb_mux(MUX_WD3_W_Sel, ALUOut_W, ReadData_W, PC8_W),
              wb_mux(mon_e.sel, mon_e.alu, mon_e.rd, mon_e.pc8));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic drive(input instr_t i);
    Valid_M       = i.valid;
    ALUOut_M      = i.alu;
    WriteData_M   = i.wd;
    PC8_M         = i.pc8;
    WriteReg_M    = i.wreg;
    RegWrite_M    = i.rw;
    MUX_WD3_Sel_M = i.sel;
    MemRead_M     = i.mr;
    MemWrite_M    = i.mw;
    LoadType_M    = i.lt;
    StoreType_M   = i.st;
  endtask

  // Presents one instruction, acks after `lat` stalled cycles, and queues the
  // expected W contents for every cycle it occupies the M stage.
  task automatic run_instr(input string tag, input instr_t i, input int lat, input logic [31:0] rdata);
    int    stalls;
    logic  mop;
    logic  al;
    wexp_t e;
    @(negedge clk);
    drive(i);
    dm_rdata = rdata;
    dm_ack   = (lat == 0);
    al  = m_aligned(i);
    mop = i.valid & (i.mr | i.mw) & al;
    #1;
    check({tag, ":dm_req"}, {31'd0, dm_req}, {31'd0, mop});
    if (mop) begin
      check({tag, ":dm_we"},   {31'd0, dm_we}, {31'd0, i.mw});
      check({tag, ":dm_addr"}, dm_addr, {i.alu[31:2], 2'b00});
      if (i.mw) begin
        check({tag, ":dm_be"},    {28'd0, dm_be}, {28'd0, m_be(i)});
        check({tag, ":dm_wdata"}, dm_wdata, m_wdata(i));
      end
    end
    stalls = 0;
    while (Stall_M === 1'b1 && stalls <= 50) begin
      e = '{tag: {tag, "(stall)"}, full: 1'b0, rd: '0, alu: '0, pc8: '0,
            wreg: '0, rw: 1'b0, sel: '0, adexc: 1'b0};
      exp_q.push_back(e);
      @(negedge clk);
      stalls++;
      if (stalls >= lat) dm_ack = 1'b1;
      #1;
      check({tag, ":dm_req_held"}, {31'd0, dm_req}, 32'd1);
    end
    check({tag, ":stall_cycles"}, stalls, mop ? lat : 0);
    e.tag   = tag;
    e.full  = 1'b1;
    e.rd    = i.mr ? m_ext(i, rdata) : 32'd0;
    e.alu   = i.alu;
    e.pc8   = i.pc8;
    e.wreg  = i.wreg;
    e.sel   = i.sel;
    e.rw    = i.valid & i.rw & ~(i.valid & (i.mr | i.mw) & ~al);
    e.adexc = i.valid & (i.mr | i.mw) & ~al;
    exp_q.push_back(e);
  endtask

  task automatic check_w_zero(input string tag);
    check({tag, ":ReadData_W"}, ReadData_W, 32'd0);
    check({tag, ":ALUOut_W"},   ALUOut_W,   32'd0);
    check({tag, ":PC8_W"},      PC8_W,      32'd0);
    check({tag, ":WriteReg_W"}, {27'd0, WriteReg_W},    32'd0);
    check({tag, ":RegWrite_W"}, {31'd0, RegWrite_W},    32'd0);
    check({tag, ":Sel_W"},      {30'd0, MUX_WD3_W_Sel}, 32'd0);
    check({tag, ":AdExc_W"},    {31'd0, AdExc_W},       32'd0);
  endtask

  instr_t ins;

  initial begin
    // Reset with an aligned lw presented: the request must stay low.
    reset_n  = 1'b0;
    dm_ack   = 1'b0;
    dm_rdata = '0;
    drive(mk_load(3'd0, 32'h0000_0100, 5'd8));
    repeat (2) @(negedge clk);
    #1;
    check("reset:dm_req", {31'd0, dm_req}, 32'd0);
    check_w_zero("reset");
    drive(nop());
    @(negedge clk);
    reset_n = 1'b1;

    // Zero-wait lw.
    run_instr("lw_0x100", mk_load(3'd0, 32'h0000_0100, 5'd8), 0, 32'hDEAD_BEEF);
    // 3-wait byte loads.
    run_instr("lb_0x103",  mk_load(3'd1, 32'h0000_0103, 5'd9),  3, 32'h80FF_7F01);
    run_instr("lbu_0x103", mk_load(3'd2, 32'h0000_0103, 5'd10), 3, 32'h80FF_7F01);
    run_instr("lb_0x101",  mk_load(3'd1, 32'h0000_0101, 5'd11), 1, 32'h80FF_7F01);
    // Halfword loads in both lanes.
    run_instr("lh_0x102",  mk_load(3'd3, 32'h0000_0102, 5'd12), 0, 32'h80FF_7F01);
    run_instr("lhu_0x102", mk_load(3'd4, 32'h0000_0102, 5'd13), 2, 32'h80FF_7F01);
    run_instr("lh_0x100",  mk_load(3'd3, 32'h0000_0100, 5'd14), 0, 32'h80FF_8F01);
    // Stores.
    run_instr("sh_0x102", mk_store(2'd2, 32'h0000_0102, 32'h1234_ABCD), 1, 32'h0);
    run_instr("sb_0x101", mk_store(2'd1, 32'h0000_0101, 32'h1234_56EF), 0, 32'h0);
    run_instr("sw_0x200", mk_store(2'd0, 32'h0000_0200, 32'hA5A5_5A5A), 2, 32'h0);
    // Misaligned accesses: trap, no request, no stall.
    run_instr("lw_0x101", mk_load(3'd0, 32'h0000_0101, 5'd15), 0, 32'h0);
    run_instr("lh_0x103", mk_load(3'd3, 32'h0000_0103, 5'd16), 0, 32'h0);
    ins = mk_store(2'd2, 32'h0000_0101, 32'h0000_BEEF);
    ins.rw = 1'b1;
    run_instr("sh_0x101", ins, 0, 32'h0);
    // jal-style PC+8 write-back.
    ins = nop();
    ins.valid = 1; ins.rw = 1; ins.sel = 2'd2; ins.pc8 = 32'h0000_3008;
    ins.alu = 32'h0000_1111; ins.wreg = 5'd31;
    run_instr("jal", ins, 0, 32'h0);
    // Plain ALU op.
    ins = nop();
    ins.valid = 1; ins.rw = 1; ins.alu = 32'h0000_0055; ins.wreg = 5'd4; ins.pc8 = 32'h0000_3010;
    run_instr("alu", ins, 0, 32'h0);
    // Bubble carrying a load with a stray ack: no request, no write.
    ins = mk_load(3'd0, 32'h0000_0300, 5'd5);
    ins.valid = 1'b0;
    run_instr("bubble_ack", ins, 0, 32'h1357_9BDF);

    // Reset during WAIT.
    @(negedge clk);
    drive(mk_load(3'd1, 32'h0000_0103, 5'd9));
    dm_ack   = 1'b0;
    dm_rdata = 32'h80FF_7F01;
    repeat (2) @(negedge clk);
    #1;
    check("rst_wait:dm_req_before", {31'd0, dm_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_wait:dm_req", {31'd0, dm_req}, 32'd0);
    check_w_zero("rst_wait");
    @(negedge clk);
    dm_ack = 1'b1;
    drive(nop());
    @(negedge clk);
    reset_n = 1'b1;
    // FSM must be back in IDLE: an idle cycle with a stray ack raises no request.
    run_instr("post_rst_idle", nop(), 0, 32'h0);
    run_instr("post_rst_lw", mk_load(3'd0, 32'h0000_0104, 5'd7), 2, 32'h0BAD_F00D);
    run_instr("post_rst_tail", nop(), 0, 32'h0);

    @(negedge clk);
    dm_ack = 1'b0;
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
